reg_dump_tx: RTL and testbench

Serial readout transmitter for the Hack CPU's 16-bit registers. It accepts one 16-bit word per load handshake, latches it the way `reg16` latches on `load`, and shifts it out on a single UART line as two 8N1 frames, high byte first. It sits beside the CPU register set (A, D, PC) as the debug/observation path. It is the outbound counterpart of the parallel-load register.

---
 rtl/hack_dbg_pkg.sv | 15 +
 rtl/reg_dump_tx_baud_tick.sv | 37 +++
 rtl/reg_dump_tx.sv | 122 ++++++++++++
 tb/tb_reg_dump_tx.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hack_dbg_pkg.sv
// Shared types and constants for the Hack debug readout path.
// Frame geometry and transmitter FSM state encoding.
package hack_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int TX_BYTES = 2;
  localparam int TX_BITS  = 8;

endpackage

// File: rtl/reg_dump_tx_baud_tick.sv
// Bit-period counter for the readout transmitter.
// Emits a one-cycle tick on the last cycle of every bit.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Count 0..LAST, wrap at the bit boundary, hold at 0 while cleared
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Serial readout of a 16-bit Hack register as two 8N1 frames.
// High byte first, LSB first within each byte, tx registered.
module reg_dump_tx
  import hack_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  output logic        ready,
  output logic        busy,
  output logic        tx,
  output logic        done
);

  tx_state_t   state_q, state_d;
  logic [15:0] hold_q,  hold_d;
  logic        idx_q,   idx_d;
  logic [2:0]  bit_q,   bit_d;
  logic        tx_q,    tx_d;
  logic        done_q,  done_d;
  logic        tick;
  logic [7:0]  byte_d;

  localparam logic [2:0] LAST_BIT  = 3'(TX_BITS - 1);
  localparam logic       LAST_BYTE = 1'(TX_BYTES - 1);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  // State register; tx forced high asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= 1'b0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state: frame sequencing, advanced on bit ticks
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          hold_d  = in;
          idx_d   = 1'b0;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (idx_q != LAST_BYTE) begin
            idx_d   = idx_q + 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: line level for the upcoming cycle and done pulse
  always_comb begin
    byte_d = idx_d ? hold_d[7:0] : hold_d[15:8];
    tx_d   = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_d[bit_d];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && tick && (idx_q == LAST_BYTE);
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx at 4 clocks per bit.
// Expected line levels come from a byte/bit frame model.
module tb_reg_dump_tx;

  localparam int CPB = 4;
  localparam int FRAME = 20 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        ready;
  logic        busy;
  logic        tx;
  logic        done;

  int checks = 0;
  int errors = 0;

  reg_dump_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .load (load),
    .ready(ready),
    .busy (busy),
    .tx   (tx),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: serial bit n of the 20-bit transfer of word w
  function automatic logic model_bit(input logic [15:0] w, input int n);
    int fr;
    int pos;
    int by;
    fr  = n / 10;
    pos = n % 10;
    by  = (fr == 0) ? (w / 256) : (w % 256);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return 1'((by >> (pos - 1)) & 1);
  endfunction

  // Called in the cycle after acceptance; ends in the done cycle
  task automatic check_transfer(input logic [15:0] w, input string tag,
                                input logic scramble);
    for (int i = 0; i < FRAME; i++) begin
      if (scramble) in = 16'($urandom);
      if (i % CPB == CPB / 2 - 1) begin
        chk($sformatf("%s_tx_b%0d", tag, i / CPB), 16'(tx),
            16'(model_bit(w, i / CPB)));
        chk($sformatf("%s_busy_b%0d", tag, i / CPB),
            16'({ready, busy, done}), 16'b010);
      end
      step();
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_ready_done"}, 16'(ready), 16'd1);
    chk({tag, "_tx_done"}, 16'(tx), 16'd1);
  endtask

  task automatic send(input logic [15:0] w, input string tag);
    in   = w;
    load = 1'b1;
    step();
    load = 1'b0;
    chk({tag, "_ready_fall"}, 16'(ready), 16'd0);
    chk({tag, "_start"}, 16'(tx), 16'd0);
    check_transfer(w, tag, 1'b1);
    step();
    chk({tag, "_done_clr"}, 16'(done), 16'd0);
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1;
    in    = '0;
    load  = 1'b0;
    #2;
    chk("rst_tx", 16'(tx), 16'd1);
    chk("rst_rdy", 16'({ready, busy, done}), 16'b100);
    repeat (3) step();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      in = 16'($urandom);
      chk($sformatf("idle_%0d", i), 16'({tx, ready, busy, done}),
          16'b1100);
      step();
    end

    send(16'h0912, "w0912");

    in   = 16'hFFFF;
    load = 1'b1;
    step();
    in = 16'h0000;
    check_transfer(16'hFFFF, "wFFFF", 1'b0);
    step();
    load = 1'b0;
    chk("w0000_accept", 16'({ready, tx}), 16'b00);
    check_transfer(16'h0000, "w0000", 1'b0);
    step();

    in   = 16'h0912;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (13) step();
    chk("pre_rst_tx", 16'(tx), 16'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", 16'(tx), 16'd1);
    chk("mid_rst_rdy", 16'({ready, busy, done}), 16'b100);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst_%0d", i), 16'({tx, ready}), 16'b11);
      step();
    end
    send(16'h0912, "again0912");

    send(16'h8001, "w8001");

    for (int r = 0; r < 4; r++) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 3)) step();
      send(w, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
